// File: rtl/boot_pkg.sv
// Shared boot-loader definitions.
//   loader_state_t : program loader FSM states
//   MAGIC          : frame start byte
//   IMEM_DEPTH     : instruction memory depth in words (same value as the cpu's PC_SIZE)
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_LO = 3'd1,
    CNT_HI = 3'd2,
    DATA   = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } loader_state_t;

  localparam logic [7:0] MAGIC      = 8'hA5;
  localparam int         IMEM_DEPTH = 8192;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// word_assembler: packs a little-endian byte stream into 32-bit words.
//   clk, reset  : clock, synchronous active-high reset
//   clear       : restart at byte 0 of a new word (takes priority over byte_valid)
//   byte_valid  : byte_in is consumed this cycle
//   byte_in     : incoming byte, LSB of the word first
//   word_valid  : combinational, high in the cycle the 4th byte is consumed
//   word        : combinational assembled word, meaningful while word_valid is high
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] shift_q, shift_d;

  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    if (clear) begin
      idx_d   = 2'd0;
      shift_d = 32'd0;
    end else if (byte_valid) begin
      // Index wraps 3 -> 0 naturally; new bytes enter at the top so that
      // after four bytes the first one sits in bits [7:0].
      idx_d   = idx_q + 2'd1;
      shift_d = {byte_in, shift_q[31:8]};
    end
  end

  assign word_valid = byte_valid && !clear && (idx_q == 2'd3);
  assign word       = {byte_in, shift_q[31:8]};

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= 2'd0;
      shift_q <= 32'd0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a framed program from the UART receiver, writes it into
// instruction memory and holds the cpu in reset until a frame with a valid
// checksum has been written.
// Frame: MAGIC, count_lo, count_hi, count*4 data bytes (LSB first), checksum
// (XOR of the data bytes).
// Byte handshake: a byte is transferred on a rising clk edge where
// rx_valid & rx_ready; rx_ready is low only in DONE and ERROR.
//   clk, reset            : clock, synchronous active-high reset
//   rx_data/valid/ready   : byte stream from the UART receiver
//   start                 : re-arm pulse, honoured only in DONE or ERROR
//   imem_we/addr/wdata    : instruction memory write port
//   cpu_hold              : active-high reset to the cpu
//   load_done, load_error : frame accepted / rejected
//   words_loaded          : words written in the current or last frame
module prog_loader
  import boot_pkg::*;
#(
  parameter int         IMEM_DEPTH     = boot_pkg::IMEM_DEPTH,
  parameter int         ADDR_W         = 13,
  parameter logic [7:0] MAGIC          = boot_pkg::MAGIC,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  loader_state_t     state_q, state_d;
  logic [7:0]        cnt_lo_q, cnt_lo_d;
  logic [15:0]       count_q, count_d;
  logic [7:0]        csum_q, csum_d;
  logic [TO_W-1:0]   timeout_q, timeout_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic [ADDR_W:0]   words_loaded_q, words_loaded_d;

  logic        accept;
  logic        timed_state;
  logic        wa_clear;
  logic        wa_valid;
  logic        word_valid;
  logic [31:0] word;
  logic [ADDR_W:0] wl_next;

  assign rx_ready    = (state_q != DONE) && (state_q != ERROR);
  assign accept      = rx_valid && rx_ready;
  assign timed_state = (state_q == CNT_LO) || (state_q == CNT_HI) ||
                       (state_q == DATA)   || (state_q == CHECK);
  // A new data phase always starts at byte 0 of a word.
  assign wa_clear    = accept && (state_q == CNT_HI);
  assign wa_valid    = accept && (state_q == DATA);
  assign wl_next     = words_loaded_q + (ADDR_W + 1)'(1);

  word_assembler u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (wa_clear),
    .byte_valid (wa_valid),
    .byte_in    (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d        = state_q;
    cnt_lo_d       = cnt_lo_q;
    count_d        = count_q;
    csum_d         = csum_q;
    imem_we_d      = 1'b0;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    words_loaded_d = words_loaded_q;

    if (!timed_state || accept) timeout_d = '0;
    else                        timeout_d = timeout_q + TO_W'(1);

    case (state_q)
      IDLE: begin
        // Line noise before a frame is dropped silently.
        if (accept && (rx_data == MAGIC)) state_d = CNT_LO;
      end
      CNT_LO: begin
        if (accept) begin
          cnt_lo_d = rx_data;
          state_d  = CNT_HI;
        end
      end
      CNT_HI: begin
        if (accept) begin
          count_d = {rx_data, cnt_lo_q};
          if ((count_d == 16'd0) || (count_d > 16'(IMEM_DEPTH))) begin
            state_d = ERROR;
          end else begin
            state_d        = DATA;
            words_loaded_d = '0;
            csum_d         = 8'd0;
          end
        end
      end
      DATA: begin
        if (accept) begin
          csum_d = csum_q ^ rx_data;
          if (word_valid) begin
            // Write is registered: it appears the cycle after the 4th byte,
            // which lets the next byte be taken without a stall.
            imem_we_d      = 1'b1;
            imem_addr_d    = words_loaded_q[ADDR_W-1:0];
            imem_wdata_d   = word;
            words_loaded_d = wl_next;
            if (16'(wl_next) == count_q) state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (accept) state_d = (rx_data == csum_q) ? DONE : ERROR;
      end
      DONE, ERROR: begin
        if (start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Only fires on cycles with no accepted byte, so it never competes with
    // a byte-driven transition.
    if (timed_state && !accept && (timeout_q >= TO_W'(TIMEOUT_CYCLES - 1)))
      state_d = ERROR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_lo_q       <= 8'd0;
      count_q        <= 16'd0;
      csum_q         <= 8'd0;
      timeout_q      <= '0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= 32'd0;
      words_loaded_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_lo_q       <= cnt_lo_d;
      count_q        <= count_d;
      csum_q         <= csum_d;
      timeout_q      <= timeout_d;
      imem_we_q      <= imem_we_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      words_loaded_q <= words_loaded_d;
    end
  end

  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign words_loaded = words_loaded_q;
  // Decoded straight from the state so they move on the same edge as the
  // transition into or out of DONE/ERROR.
  assign cpu_hold     = (state_q != DONE);
  assign load_done    = (state_q == DONE);
  assign load_error   = (state_q == ERROR);

endmodule
